osd_event_packetizer: RTL and testbench
=======================================

Name: osd_event_packetizer

Overview:
- Converts one wide event word from a debug module into DII packets and drives them into a ring router's local input port.
- Sits between a trace/event source inside a debug module and the debug ring.
- Splits events wider than one packet's payload into several packets. The final packet is tagged "last fragment".

Parameters:
- DATA_WIDTH, 32: width of event_data in bits, >=1. Payload words per event NW = ceil(DATA_WIDTH/16).
- MAX_PKT_LEN, 12: maximum DII packet length in 16-bit words including the 3 header words, >=4. Payload words per packet PPW = MAX_PKT_LEN-3.

Ports:
- clk  input  1  clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- id  input  16  source address of this module, sampled when an event is accepted.
- dest  input  16  destination address, sampled when an event is accepted.
- event_available  input  1  event_data is valid.
- event_data  input  DATA_WIDTH  event payload.
- event_consumed  output  1  event accepted this cycle (combinational).
- debug_out  dii_channel master  data 16 / valid 1 / last 1 out, ready 1 in  packet stream toward the ring router local_in.

Behaviour:
- FSM states: IDLE, DEST, SRC, FLAGS, PAYLOAD.
- event_consumed = (state==IDLE) && event_available && !rst.
- On acceptance:
  - capture event_data, id and dest;
  - zero-extend event_data to NW*16 bits;
  - set word index widx=0;
  - go to DEST.
- Next-event acceptance is blocked until the final packet's last word has handshaked.
- Word handshake: a word transfers on a cycle with valid && ready. While ready=0, data, valid and last hold stable.
- DEST: data=dest, valid=1, last=0. On handshake go to SRC.
- SRC: data=id, valid=1, last=0. On handshake go to FLAGS.
- FLAGS: data={2'b10 (TYPE_EVENT), subtype[3:0], 10'b0}, valid=1, last=0. On handshake go to PAYLOAD.
  - subtype = EV_LAST (0) if the remaining words (NW-widx) <= PPW.
  - subtype = EV_CONT (1) otherwise.
- PAYLOAD:
  - data = captured bits [16*widx+15 : 16*widx]; the least significant word goes first.
  - last = 1 on the final word of the packet, i.e. when the packet word count reaches PPW or widx==NW-1.
  - On handshake: widx++.
  - If last and widx was NW-1: go to IDLE.
  - If last otherwise: go to DEST and start the next fragment, reusing the captured dest and id.
- Latency:
  - event accepted at edge t;
  - debug_out.valid=1 from cycle t+1;
  - with ready held at 1, a single-packet event finishes in NW+3 cycles;
  - the earliest next acceptance is the cycle after the last handshake.
- Counter widths:
  - widx is clog2(NW+1) bits;
  - the per-packet payload counter is clog2(PPW+1) bits.
  - Neither counter wraps before reset to 0 at the next acceptance.
- Reset, including mid-packet: next cycle state=IDLE, debug_out.valid=0, last=0, data=0, event_consumed=0. A partially sent event is discarded and not re-requested.
- Changes to event_data, id or dest after acceptance have no effect on the packet in flight.
- All debug_out outputs are registered. ready is never required to be high for valid to assert.

Decomposition:
- Package osd_dii_pkg holds:
  - TYPE_EVENT = 2'b10;
  - EV_LAST = 4'd0 and EV_CONT = 4'd1;
  - the header word indices;
  - a function computing NW from DATA_WIDTH.
- No sub-module: one FSM with a payload register and two counters.

Test Plan:
- Single packet, DATA_WIDTH=32, id=0x0005, dest=0x0000, event_data=0x12345678, ready=1:
  - words 0x0000, 0x0005, 0x8000, 0x5678, 0x1234;
  - last only on 0x1234;
  - event_consumed a 1-cycle pulse;
  - 5 consecutive handshakes.
- Fragmentation, DATA_WIDTH=160, MAX_PKT_LEN=8:
  - two packets of 8 words each;
  - first FLAGS=0x8400 with payload words 0-4, second FLAGS=0x8000 with payload words 5-9;
  - both packets carry the same dest/src.
- Padding, DATA_WIDTH=40, event_data=0xAB_CDEF_0123:
  - payload 0x0123, 0xCDEF, 0x00AB;
  - last on 0x00AB.
- Backpressure: ready toggling 1,0,0,1 during SRC and PAYLOAD:
  - data/valid/last stable during stalls;
  - no word dropped or duplicated;
  - event_available held high throughout gives no second event_consumed until after the final handshake.
- Mid-packet reset: assert rst for 1 cycle during PAYLOAD:
  - next cycle valid=0, last=0, event_consumed=0;
  - a new event afterwards produces a complete, correct packet starting with dest.
- Input change after acceptance: change event_data/id/dest the cycle after acceptance -> emitted packet carries the originally captured values.

Source files
------------

// File: rtl/osd_dii_pkg.sv
// osd_dii_pkg
// Shared DII packet definitions for the event packetizer:
//   - packet type / event subtype codes carried in the FLAGS header word
//   - header word indices and header length
//   - packetizer FSM state encoding
//   - helpers for payload word count and FLAGS word construction
package osd_dii_pkg;

  localparam logic [1:0] TYPE_EVENT = 2'b10;

  localparam logic [3:0] EV_LAST = 4'd0;
  localparam logic [3:0] EV_CONT = 4'd1;

  localparam int HDR_DEST  = 0;
  localparam int HDR_SRC   = 1;
  localparam int HDR_FLAGS = 2;
  localparam int HDR_WORDS = HDR_FLAGS + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DEST,
    ST_SRC,
    ST_FLAGS,
    ST_PAYLOAD
  } pkt_state_e;

  // Number of 16-bit payload words needed to carry an event of data_width bits.
  function automatic int payload_words(input int data_width);
    return (data_width + 15) / 16;
  endfunction

  function automatic logic [15:0] flags_word(input logic [3:0] subtype);
    return {TYPE_EVENT, subtype, 10'b0};
  endfunction

endpackage

// File: rtl/osd_event_packetizer.sv
// osd_event_packetizer
// Turns one wide event word into one or more DII packets (dest, src, flags,
// payload...). Events longer than one packet's payload are fragmented; every
// fragment but the final one is tagged EV_CONT, the final one EV_LAST.
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   id, dest             source / destination address, captured on acceptance
//   event_available      event_data is valid
//   event_data           event payload (DATA_WIDTH bits)
//   event_consumed       event accepted this cycle (combinational)
//   debug_out_data/valid/last  registered packet stream toward the ring router
//   debug_out_ready      ring router can take a word this cycle
module osd_event_packetizer
  import osd_dii_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int MAX_PKT_LEN = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           id,
  input  logic [15:0]           dest,
  input  logic                  event_available,
  input  logic [DATA_WIDTH-1:0] event_data,
  output logic                  event_consumed,
  output logic [15:0]           debug_out_data,
  output logic                  debug_out_valid,
  output logic                  debug_out_last,
  input  logic                  debug_out_ready
);

  localparam int NW     = payload_words(DATA_WIDTH);
  localparam int PPW    = MAX_PKT_LEN - HDR_WORDS;
  localparam int PW     = NW * 16;
  localparam int WIDX_W = $clog2(NW + 1);
  localparam int PCNT_W = $clog2(PPW + 1);

  localparam logic [WIDX_W-1:0] WIDX_LAST = WIDX_W'(NW - 1);
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PPW - 1);

  pkt_state_e        state_reg;
  logic [PW-1:0]     payload_reg;
  logic [15:0]       dest_reg;
  logic [15:0]       id_reg;
  logic [WIDX_W-1:0] widx_reg;
  logic [PCNT_W-1:0] pcnt_reg;
  logic [15:0]       data_reg;
  logic              valid_reg;
  logic              last_reg;

  logic [WIDX_W-1:0] widx_next;
  logic [PCNT_W-1:0] pcnt_next;
  logic [15:0]       cur_word;
  logic [15:0]       next_word;
  logic              more_frags;
  logic              first_is_last;

  // Captured payload viewed as an array of 16-bit words, LSW at index 0.
  logic [15:0] word_arr [NW];

  genvar gi;
  generate
    for (gi = 0; gi < NW; gi++) begin : g_words
      assign word_arr[gi] = payload_reg[gi*16 +: 16];
    end
  endgenerate

  assign event_consumed = (state_reg == ST_IDLE) && event_available && !rst;

  always_comb begin
    widx_next     = widx_reg + WIDX_W'(1);
    pcnt_next     = pcnt_reg + PCNT_W'(1);
    cur_word      = word_arr[widx_reg];
    // widx_next reaches NW only after the final word, where it is never used.
    next_word     = (int'(widx_next) < NW) ? word_arr[widx_next] : 16'h0000;
    // More fragments follow when the remaining words exceed one packet.
    more_frags    = (int'(widx_reg) + PPW) < NW;
    first_is_last = (PCNT_LAST == '0) || (widx_reg == WIDX_LAST);
  end

  // Outputs are loaded with the word of the state being entered, so the
  // stream is fully registered and only advances on a valid&&ready handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      widx_reg  <= '0;
      pcnt_reg  <= '0;
      data_reg  <= '0;
      valid_reg <= 1'b0;
      last_reg  <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (event_available) begin
            payload_reg <= PW'(event_data);
            dest_reg    <= dest;
            id_reg      <= id;
            widx_reg    <= '0;
            pcnt_reg    <= '0;
            data_reg    <= dest;
            valid_reg   <= 1'b1;
            last_reg    <= 1'b0;
            state_reg   <= ST_DEST;
          end
        end
        ST_DEST: begin
          if (debug_out_ready) begin
            data_reg  <= id_reg;
            state_reg <= ST_SRC;
          end
        end
        ST_SRC: begin
          if (debug_out_ready) begin
            data_reg  <= flags_word(more_frags ? EV_CONT : EV_LAST);
            state_reg <= ST_FLAGS;
          end
        end
        ST_FLAGS: begin
          if (debug_out_ready) begin
            data_reg  <= cur_word;
            last_reg  <= first_is_last;
            pcnt_reg  <= '0;
            state_reg <= ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          if (debug_out_ready) begin
            widx_reg <= widx_next;
            pcnt_reg <= pcnt_next;
            if (last_reg) begin
              last_reg <= 1'b0;
              if (widx_reg == WIDX_LAST) begin
                data_reg  <= '0;
                valid_reg <= 1'b0;
                state_reg <= ST_IDLE;
              end else begin
                // Next fragment reuses the captured addresses.
                data_reg  <= dest_reg;
                state_reg <= ST_DEST;
              end
            end else begin
              data_reg <= next_word;
              last_reg <= (pcnt_next == PCNT_LAST) || (widx_next == WIDX_LAST);
            end
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          valid_reg <= 1'b0;
          last_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign debug_out_data  = data_reg;
  assign debug_out_valid = valid_reg;
  assign debug_out_last  = last_reg;

endmodule

// File: tb/tb_osd_event_packetizer.sv
// tb_osd_event_packetizer
// Three packetizer instances: (32,12) single packet, (160,8) two fragments,
// (40,12) padded payload. Expected word streams come from a packet-building
// model over the event value; responses are checked word by word.
module tb_osd_event_packetizer;

  localparam int NDUT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [159:0] ev_data  [NDUT];
  logic [15:0]  ev_id    [NDUT];
  logic [15:0]  ev_dest  [NDUT];
  logic         ev_avail [NDUT];
  logic         ready    [NDUT];
  logic         consumed [NDUT];
  logic [15:0]  o_data   [NDUT];
  logic         o_valid  [NDUT];
  logic         o_last   [NDUT];

  int dw_tab  [NDUT] = '{32, 160, 40};
  int mpl_tab [NDUT] = '{12, 8, 12};

  int checks   = 0;
  int failures = 0;

  logic [16:0] exp_q [$];

  always #5 clk = ~clk;

  osd_event_packetizer #(.DATA_WIDTH(32), .MAX_PKT_LEN(12)) u_d32 (
    .clk(clk), .rst(rst), .id(ev_id[0]), .dest(ev_dest[0]),
    .event_available(ev_avail[0]), .event_data(ev_data[0][31:0]),
    .event_consumed(consumed[0]), .debug_out_data(o_data[0]),
    .debug_out_valid(o_valid[0]), .debug_out_last(o_last[0]),
    .debug_out_ready(ready[0]));

  osd_event_packetizer #(.DATA_WIDTH(160), .MAX_PKT_LEN(8)) u_d160 (
    .clk(clk), .rst(rst), .id(ev_id[1]), .dest(ev_dest[1]),
    .event_available(ev_avail[1]), .event_data(ev_data[1]),
    .event_consumed(consumed[1]), .debug_out_data(o_data[1]),
    .debug_out_valid(o_valid[1]), .debug_out_last(o_last[1]),
    .debug_out_ready(ready[1]));

  osd_event_packetizer #(.DATA_WIDTH(40), .MAX_PKT_LEN(12)) u_d40 (
    .clk(clk), .rst(rst), .id(ev_id[2]), .dest(ev_dest[2]),
    .event_available(ev_avail[2]), .event_data(ev_data[2][39:0]),
    .event_consumed(consumed[2]), .debug_out_data(o_data[2]),
    .debug_out_valid(o_valid[2]), .debug_out_last(o_last[2]),
    .debug_out_ready(ready[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Reference: slice the zero-padded event into packets of up to PPW payload
  // words, each preceded by dest, src and a flags word (0x8400 if more follow).
  task automatic build_expected(input logic [159:0] d, input logic [15:0] i_id,
                                input logic [15:0] i_dest, input int dw, input int mpl);
    logic [159:0] v;
    int nw, ppw, n;
    v = d;
    for (int b = dw; b < 160; b++) v[b] = 1'b0;
    nw  = (dw + 15) / 16;
    ppw = mpl - 3;
    exp_q.delete();
    for (int base = 0; base < nw; base += ppw) begin
      n = (nw - base < ppw) ? (nw - base) : ppw;
      exp_q.push_back({1'b0, i_dest});
      exp_q.push_back({1'b0, i_id});
      exp_q.push_back({1'b0, (nw - base > ppw) ? 16'h8400 : 16'h8000});
      for (int j = 0; j < n; j++)
        exp_q.push_back({(j == n - 1), v[16*(base+j) +: 16]});
    end
  endtask

  // Called #1 after a rising edge. mode: 0 ready=1, 1 pattern 1,0,0,1, 2 random.
  task automatic run_event(input int k, input logic [159:0] d, input logic [15:0] i_id,
                           input logic [15:0] i_dest, input int mode, input bit hold,
                           input bit chg, input int abort_at);
    logic [16:0] e;
    logic [15:0] pd;
    logic pl, ry;
    bit stalled;
    int n_words, hs, cyc;
    stalled = 1'b0;
    hs = 0;
    cyc = 0;
    pd = '0;
    pl = 1'b0;
    build_expected(d, i_id, i_dest, dw_tab[k], mpl_tab[k]);
    n_words = exp_q.size();
    ev_data[k]  = d;
    ev_id[k]    = i_id;
    ev_dest[k]  = i_dest;
    ev_avail[k] = 1'b1;
    ready[k]    = 1'b0;
    #1;
    chk("consumed_on_offer", consumed[k], 1);
    @(posedge clk); #1;
    if (!hold) ev_avail[k] = 1'b0;
    if (chg) begin
      ev_data[k] = ~d;
      ev_id[k]   = ~i_id;
      ev_dest[k] = ~i_dest;
    end
    while (exp_q.size() > 0 && cyc < 400) begin
      case (mode)
        0:       ry = 1'b1;
        1:       ry = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: ry = 1'($urandom_range(0, 1));
      endcase
      ready[k] = ry;
      chk("valid_busy", o_valid[k], 1);
      if (stalled) begin
        chk("stall_data", o_data[k], pd);
        chk("stall_last", o_last[k], pl);
      end
      if (hold) chk("no_second_accept", consumed[k], 0);
      if (ry) begin
        e = exp_q.pop_front();
        chk("word_data", o_data[k], e[15:0]);
        chk("word_last", o_last[k], e[16]);
        hs++;
      end
      pd = o_data[k];
      pl = o_last[k];
      stalled = !ry;
      if (abort_at >= 0 && hs == abort_at) begin
        ev_avail[k] = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        ready[k] = 1'b0;
        chk("rst_valid", o_valid[k], 0);
        chk("rst_last", o_last[k], 0);
        chk("rst_data", o_data[k], 0);
        chk("rst_consumed", consumed[k], 0);
        $display("txn dut=%0d aborted by reset after %0d handshakes", k, hs);
        exp_q.delete();
        return;
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk("words_left", exp_q.size(), 0);
    chk("valid_idle", o_valid[k], 0);
    chk("last_idle", o_last[k], 0);
    if (mode == 0) chk("burst_cycles", cyc, n_words);
    if (hold) begin
      chk("reaccept_ready", consumed[k], 1);
      ev_avail[k] = 1'b0;
    end
    ready[k] = 1'b0;
    $display("txn dut=%0d data=%0h id=%04h dest=%04h words=%0d cycles=%0d mode=%0d",
             k, d, i_id, i_dest, n_words, cyc, mode);
  endtask

  initial begin
    logic [159:0] rd;
    int k;
    for (int i = 0; i < NDUT; i++) begin
      ev_data[i] = '0; ev_id[i] = '0; ev_dest[i] = '0;
      ev_avail[i] = 1'b1; ready[i] = 1'b0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < NDUT; i++) begin
      chk("reset_valid", o_valid[i], 0);
      chk("reset_last", o_last[i], 0);
      chk("reset_data", o_data[i], 0);
      chk("reset_consumed", consumed[i], 0);
      ev_avail[i] = 1'b0;
    end
    rst = 1'b0;
    @(posedge clk); #1;

    // Single packet
    run_event(0, 160'h12345678, 16'h0005, 16'h0000, 0, 0, 0, -1);
    // Fragmentation into two 8-word packets
    rd = {$urandom, $urandom, $urandom, $urandom, $urandom};
    run_event(1, rd, 16'h0011, 16'h0022, 0, 0, 0, -1);
    // Padding of the top word (bits above 40 are not connected)
    run_event(2, {120'hFFFF_0000_1111, 40'hAB_CDEF_0123}, 16'h0003, 16'h0004, 0, 0, 0, -1);
    // Backpressure with event_available held
    run_event(0, 160'hDEADBEEF, 16'h0101, 16'h0202, 1, 1, 0, -1);
    rd = {$urandom, $urandom, $urandom, $urandom, $urandom};
    run_event(1, rd, 16'h0303, 16'h0404, 1, 1, 0, -1);
    // Mid-packet reset, then a complete packet
    rd = {$urandom, $urandom, $urandom, $urandom, $urandom};
    run_event(1, rd, 16'h0505, 16'h0606, 0, 0, 0, 5);
    rd = {$urandom, $urandom, $urandom, $urandom, $urandom};
    run_event(1, rd, 16'h0707, 16'h0808, 0, 0, 0, -1);
    // Inputs change right after acceptance
    run_event(0, 160'hCAFE_F00D, 16'h1234, 16'h4321, 2, 0, 1, -1);
    run_event(2, 160'h55_AAAA_5555, 16'h0F0F, 16'hF0F0, 0, 0, 1, -1);
    // Random events
    for (int t = 0; t < 24; t++) begin
      k  = int'($urandom_range(0, NDUT - 1));
      rd = {$urandom, $urandom, $urandom, $urandom, $urandom};
      run_event(k, rd, 16'($urandom), 16'($urandom), 2, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
